// File: rtl/mips_pkg.sv
// Shared pipeline constants, the fetch FSM state type and default parameter values
// used by the IF stage controller and its IF/ID register.
package mips_pkg;

    localparam int unsigned DEF_AW        = 32;
    localparam int unsigned DEF_CTRL_W    = 10;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;   // sll $0,$0,0
    localparam int unsigned PC_INC        = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_stage_ctrl_if.sv
// Instruction-memory fetch handshake between the IF stage (master) and imem (slave).
// The address is held stable while imem_req is high; imem_valid may come back late.
interface if_stage_ctrl_if #(
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/if_stage_ctrl_ifid_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load; when neither hold nor
// load applies, a NOP bubble (valid=0) is loaded and the stored PC+4 is kept.
module ifid_reg
    import mips_pkg::*;
#(
    parameter int          AW        = DEF_AW,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          hold,
    input  logic          load,
    input  logic [AW-1:0] pc_in,
    input  logic [31:0]   instr_in,
    output logic [AW-1:0] pc_out,
    output logic [31:0]   instr_out,
    output logic          valid_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out    <= '0;
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
        end else if (flush) begin
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                pc_out    <= pc_in;
                instr_out <= instr_in;
                valid_out <= 1'b1;
            end else begin
                instr_out <= NOP_INSTR;
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage_ctrl.sv
// IF stage controller: PC register, fetch FSM (BOOT/FETCH/DROP), IF/ID register and the
// registered ID/EX bubble mux. Optional perf counters under `IF_STAGE_PERF_CNT_EN.
module if_stage_ctrl
    import mips_pkg::*;
#(
    parameter int            AW        = DEF_AW,
    parameter logic [AW-1:0] RESET_PC  = AW'(DEF_RESET_PC),
    parameter logic [31:0]   NOP_INSTR = DEF_NOP_INSTR,
    parameter int            CTRL_W    = DEF_CTRL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write,
    input  logic               ifid_write,
    input  logic               id_bubble,
    input  logic               branch_taken,
    input  logic [AW-1:0]      branch_target,
    if_stage_ctrl_if.master    imem,
    output logic [AW-1:0]      if_id_pc,
    output logic [31:0]        if_id_instr,
    output logic               if_id_valid,
    input  logic [CTRL_W-1:0]  ctrl_in,
    output logic [CTRL_W-1:0]  idex_ctrl
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    fetch_state_t  state, state_nxt;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] drop_addr;
    logic          drop_sel;
    logic          fetch_done;
    logic          fetch_accept;

    assign pc_plus4     = pc + AW'(PC_INC);
    assign fetch_done   = (state == FETCH) && imem.imem_valid;
    // A completed fetch is only consumed when the PC may advance; otherwise it is refetched.
    assign fetch_accept = fetch_done && pc_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   if (branch_taken && !imem.imem_valid) state_nxt = DROP;
            DROP:    if (imem.imem_valid) state_nxt = FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        imem.imem_req = (state != BOOT);
        drop_sel      = (state == DROP);
        imem.imem_addr = drop_sel ? drop_addr : pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= branch_target;
        end else if (fetch_accept) begin
            pc <= pc_plus4;
        end
    end

    // The abandoned request keeps its address on the bus until imem answers it.
    always_ff @(posedge clk) begin
        if ((state == FETCH) && branch_taken && !imem.imem_valid) begin
            drop_addr <= pc;
        end
    end

    ifid_reg #(
        .AW        (AW),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (branch_taken),
        .hold      (!ifid_write),
        .load      (fetch_accept),
        .pc_in     (pc_plus4),
        .instr_in  (imem.imem_rdata),
        .pc_out    (if_id_pc),
        .instr_out (if_id_instr),
        .valid_out (if_id_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ctrl <= '0;
        end else begin
            idex_ctrl <= id_bubble ? '0 : ctrl_in;
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state == FETCH) && !pc_write) stall_cnt <= sat_inc(stall_cnt);
            if (branch_taken)                  flush_cnt <= sat_inc(flush_cnt);
        end
    end
`endif

    // Advancing the PC while IF/ID holds would lose an instruction.
    a_pc_without_ifid: assert property (@(posedge clk) disable iff (!rst_n)
        !(pc_write && !ifid_write));

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: a table of per-cycle vectors plus hand-written
// sequences for DROP re-redirect, PC wrap and reset in the middle of DROP.
module tb_if_stage_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic        pw;
        logic        iw;
        logic        bub;
        logic        br;
        logic [31:0] tgt;
        logic        val;
        logic [9:0]  ctrl;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [9:0]  e_ctrl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b1;
    logic        ifid_write = 1'b1;
    logic        id_bubble = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        tb_valid = 1'b0;
    logic [9:0]  ctrl_in = '0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [9:0]  idex_ctrl;

    int checks = 0;
    int errors = 0;
    vec_t vecs[27];

    if_stage_ctrl_if #(.AW(32)) imem_bus ();

    // imem returns a word tagged with its own address so stale data is recognisable.
    assign imem_bus.imem_rdata = {16'hA5A5, imem_bus.imem_addr[15:0]};
    assign imem_bus.imem_valid = tb_valid;

    if_stage_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .id_bubble     (id_bubble),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem_bus),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .ctrl_in       (ctrl_in),
        .idex_ctrl     (idex_ctrl)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] a(input logic [15:0] addr);
        return {16'hA5A5, addr};
    endfunction

    function automatic vec_t mk(input logic pw, iw, bub, br, input logic [31:0] tgt,
                                input logic val, input logic [9:0] ctrl,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_v, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [9:0] e_ctrl);
        vec_t v;
        v.pw = pw; v.iw = iw; v.bub = bub; v.br = br; v.tgt = tgt; v.val = val;
        v.ctrl = ctrl; v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_ctrl = e_ctrl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic pw, iw, bub, br, input logic [31:0] tgt,
                       input logic val, input logic [9:0] ctrl);
        pc_write = pw; ifid_write = iw; id_bubble = bub; branch_taken = br;
        branch_target = tgt; tb_valid = val; ctrl_in = ctrl;
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_v, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic [9:0] e_ctrl);
        chk({tag, " imem_req"},    32'(imem_bus.imem_req), 32'(e_req));
        chk({tag, " imem_addr"},   imem_bus.imem_addr,     e_addr);
        chk({tag, " if_id_valid"}, 32'(if_id_valid),       32'(e_v));
        chk({tag, " if_id_pc"},    if_id_pc,               e_pc);
        chk({tag, " if_id_instr"}, if_id_instr,            e_instr);
        chk({tag, " idex_ctrl"},   32'(idex_ctrl),         32'(e_ctrl));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //               pw iw bub br tgt          val ctrl    | req addr          v  pc            instr        ctrl
        vecs[0]  = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   0, 32'h0,   0, 32'h0,   NOP,      10'h000);
        vecs[1]  = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h0,   0, 32'h0,   NOP,      10'h000);
        vecs[2]  = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h4,   1, 32'h4,   a(16'h0), 10'h000);
        vecs[3]  = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h8,   1, 32'h8,   a(16'h4), 10'h000);
        vecs[4]  = mk(1, 1, 1, 0, 32'h0,   1, 10'h3FF,   1, 32'hC,   1, 32'hC,   a(16'h8), 10'h000);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,   1, 10'h3FF,   1, 32'h10,  1, 32'h10,  a(16'hC), 10'h000);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,   1, 10'h3FF,   1, 32'h10,  1, 32'h10,  a(16'hC), 10'h3FF);
        vecs[7]  = mk(1, 1, 0, 0, 32'h0,   1, 10'h155,   1, 32'h10,  1, 32'h10,  a(16'hC), 10'h3FF);
        vecs[8]  = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h14,  1, 32'h14,  a(16'h10), 10'h155);
        vecs[9]  = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h18,  1, 32'h18,  a(16'h14), 10'h000);
        vecs[10] = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h1C,  1, 32'h1C,  a(16'h18), 10'h000);
        vecs[11] = mk(1, 1, 0, 0, 32'h0,   0, 10'h000,   1, 32'h20,  1, 32'h20,  a(16'h1C), 10'h000);
        vecs[12] = mk(1, 1, 0, 0, 32'h0,   0, 10'h000,   1, 32'h20,  0, 32'h20,  NOP,      10'h000);
        vecs[13] = mk(1, 1, 0, 0, 32'h0,   0, 10'h000,   1, 32'h20,  0, 32'h20,  NOP,      10'h000);
        vecs[14] = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h20,  0, 32'h20,  NOP,      10'h000);
        vecs[15] = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h24,  1, 32'h24,  a(16'h20), 10'h000);
        vecs[16] = mk(1, 1, 0, 1, 32'h40,  1, 10'h000,   1, 32'h28,  1, 32'h28,  a(16'h24), 10'h000);
        vecs[17] = mk(1, 1, 0, 0, 32'h0,   0, 10'h000,   1, 32'h40,  0, 32'h28,  NOP,      10'h000);
        vecs[18] = mk(1, 1, 0, 1, 32'h100, 0, 10'h000,   1, 32'h40,  0, 32'h28,  NOP,      10'h000);
        vecs[19] = mk(1, 1, 0, 0, 32'h0,   0, 10'h000,   1, 32'h40,  0, 32'h28,  NOP,      10'h000);
        vecs[20] = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h40,  0, 32'h28,  NOP,      10'h000);
        vecs[21] = mk(1, 1, 0, 0, 32'h0,   0, 10'h000,   1, 32'h100, 0, 32'h28,  NOP,      10'h000);
        vecs[22] = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h100, 0, 32'h28,  NOP,      10'h000);
        vecs[23] = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h104, 1, 32'h104, a(16'h100), 10'h000);
        vecs[24] = mk(0, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h108, 1, 32'h108, a(16'h104), 10'h000);
        vecs[25] = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h108, 0, 32'h108, NOP,      10'h000);
        vecs[26] = mk(1, 1, 0, 0, 32'h0,   1, 10'h000,   1, 32'h10C, 1, 32'h10C, a(16'h108), 10'h000);

        // Reset values while rst_n is held low.
        tb_valid = 1'b1;
        @(negedge clk);
        #1 chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 10'h000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drv(vecs[i].pw, vecs[i].iw, vecs[i].bub, vecs[i].br, vecs[i].tgt,
                vecs[i].val, vecs[i].ctrl);
            #1 chk_all($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v,
                       vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_ctrl);
            next_cycle();
        end

        // Second redirect while DROP waits for the abandoned 0x110 fetch.
        drv(1, 1, 0, 1, 32'h200, 0, 10'h000);
        #1 chk_all("drop_a1", 1'b1, 32'h110, 1'b1, 32'h110, a(16'h10C), 10'h000);
        next_cycle();
        drv(1, 1, 0, 1, 32'h300, 0, 10'h000);
        #1 chk_all("drop_a2", 1'b1, 32'h110, 1'b0, 32'h110, NOP, 10'h000);
        next_cycle();
        drv(1, 1, 0, 0, 32'h0, 1, 10'h000);
        #1 chk_all("drop_a3", 1'b1, 32'h110, 1'b0, 32'h110, NOP, 10'h000);
        next_cycle();
        drv(1, 1, 0, 0, 32'h0, 1, 10'h000);
        #1 chk_all("drop_a4", 1'b1, 32'h300, 1'b0, 32'h110, NOP, 10'h000);
        next_cycle();

        // PC wrap from 0xFFFFFFFC to 0.
        drv(1, 1, 0, 1, 32'hFFFF_FFFC, 1, 10'h000);
        #1 chk_all("wrap_a5", 1'b1, 32'h304, 1'b1, 32'h304, a(16'h300), 10'h000);
        next_cycle();
        drv(1, 1, 0, 0, 32'h0, 1, 10'h000);
        #1 chk_all("wrap_a6", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h304, NOP, 10'h000);
        next_cycle();
        drv(1, 1, 0, 0, 32'h0, 1, 10'h000);
        #1 chk_all("wrap_a7", 1'b1, 32'h0, 1'b1, 32'h0, a(16'hFFFC), 10'h000);
        next_cycle();

        // Reset asserted in the middle of DROP; the late imem_valid must be ignored.
        drv(1, 1, 0, 1, 32'h500, 0, 10'h2AA);
        #1 chk_all("rst_a8", 1'b1, 32'h4, 1'b1, 32'h4, a(16'h0), 10'h000);
        next_cycle();
        drv(1, 1, 0, 0, 32'h0, 0, 10'h000);
        #1 chk_all("rst_a9", 1'b1, 32'h4, 1'b0, 32'h4, NOP, 10'h2AA);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_async", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 10'h000);
        tb_valid = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        drv(1, 1, 0, 0, 32'h0, 1, 10'h000);
        #1 chk_all("rst_boot", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 10'h000);
        next_cycle();
        #1 chk_all("rst_fetch", 1'b1, 32'h0, 1'b0, 32'h0, NOP, 10'h000);
        next_cycle();
        #1 chk_all("rst_first", 1'b1, 32'h4, 1'b1, 32'h4, a(16'h0), 10'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage_ctrl.md
Name: if_stage_ctrl

Overview:
- Consumer end of the load-use hazard interface. Receives the hazard unit's PC-write, IF/ID-write and bubble-select signals, plus the branch redirect.
- Owns the PC register, the instruction-memory fetch handshake, the IF/ID pipeline register and the registered ID/EX control bubble mux.
- Sits between instruction memory and the ID stage of the 5-stage MIPS pipeline.

Parameters:
- AW, 32, PC/address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction word injected on flush/bubble (sll $0,$0,0)
- CTRL_W, 10, width of ID-stage control bundle passed to ID/EX

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- pc_write  in  1  1 = PC may advance (0 = hazard stall)
- ifid_write  in  1  1 = IF/ID may load (0 = hold)
- id_bubble  in  1  1 = zero control bundle into ID/EX
- branch_taken  in  1  redirect request from ID
- branch_target  in  AW  redirect address
- imem_req  out  1  fetch request; address held stable while high
- imem_addr  out  AW  fetch address (= PC)
- imem_rdata  in  32  fetched instruction
- imem_valid  in  1  imem_rdata valid for current imem_addr; same cycle or later
- if_id_pc  out  AW  PC+4 of instruction in IF/ID
- if_id_instr  out  32  instruction in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction
- ctrl_in  in  CTRL_W  decoded control from ID
- idex_ctrl  out  CTRL_W  registered control to ID/EX

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: PC=RESET_PC, state=BOOT, imem_req=0, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, idex_ctrl=0.
- FSM states: BOOT, FETCH, DROP.
  - BOOT: one cycle after reset release, imem_req=0, then FETCH.
  - FETCH: imem_req=1, imem_addr=PC. A fetch completes in the cycle imem_valid=1.
  - DROP: entered when branch_taken arrives in FETCH with imem_valid=0. Keeps imem_req=1 and imem_addr at the old PC until imem_valid. Discards that data, then returns to FETCH with the new PC. PC already holds branch_target.
- Branch redirect:
  - branch_taken has highest priority in any state: PC<=branch_target; IF/ID<=NOP_INSTR, valid=0.
  - branch_taken in DROP: PC updates again; DROP persists.
  - branch_taken with imem_valid=1 in FETCH: data discarded, stay in FETCH.
- PC advance: fetch completes and pc_write=1 -> PC<=PC+4 (wraps mod 2^AW).
  - Fetch completes with pc_write=0: PC holds, data dropped, same address refetched next cycle.
- IF/ID (no branch):
  - ifid_write=0 -> hold all fields.
  - ifid_write=1 and fetch complete -> load imem_rdata, PC+4, valid=1.
  - ifid_write=1 and no completion (FETCH waiting, BOOT, DROP) -> load NOP_INSTR, valid=0.
- pc_write=1 with ifid_write=0 is illegal; assertion fires, PC still obeys pc_write.
- idex_ctrl: every cycle <= id_bubble ? 0 : ctrl_in. Independent of other stalls; 1-cycle latency.
- Reset mid-fetch: outstanding fetch abandoned, BOOT re-entered. imem may still return valid during BOOT; it is ignored.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- With the macro defined, adds outputs `stall_cnt` (32) and `flush_cnt` (32), both reset to 0 and saturating at all-ones:
  - stall_cnt increments each cycle pc_write=0 in FETCH.
  - flush_cnt increments each cycle branch_taken=1.
- Without it, those ports and registers do not exist.

Decomposition:
- Shared package `mips_pkg`: NOP_INSTR, RESET_PC, PC increment (4), FSM state enum (BOOT/FETCH/DROP), CTRL_W.
- Sub-module `ifid_reg`: IF/ID register with hold, flush and bubble-load controls. FSM and PC stay in top.

Test Plan:
- Reset, imem_valid tied 1 -> imem_req low 1 cycle; imem_addr 0x0,0x4,0x8; if_id_valid rises 1 cycle after first fetch; if_id_pc=0x4.
- pc_write=ifid_write=0 for 2 cycles at PC=0x10 -> PC stays 0x10, IF/ID holds; resumes 0x14 after release.
- id_bubble=1 with ctrl_in=0x3FF -> idex_ctrl=0x000 next cycle; id_bubble=0 -> 0x3FF.
- imem_valid delayed 3 cycles at PC=0x20 -> imem_addr stable 0x20, if_id_valid=0 meanwhile, then instruction loads with if_id_pc=0x24.
- branch_taken to 0x100 while fetch of 0x40 pending -> DROP; returning 0x40 data discarded; next request addr 0x100; if_id_valid=0 until 0x100 arrives.
- rst_n asserted mid-DROP -> all outputs at reset values immediately; late imem_valid ignored; refetch from RESET_PC.
